// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, multicycle FSM states, datapath select encodings
// and the control word produced by the state decoder.
package riscv_pkg;

    typedef enum logic [6:0] {
        OpLw    = 7'b0000011,
        OpSw    = 7'b0100011,
        OpBeq   = 7'b1100011,
        OpIType = 7'b0010011,
        OpRType = 7'b0110011,
        OpJal   = 7'b1101111
    } opcode_e;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StTrap
    } mc_state_e;

    localparam logic [1:0] SrcAPc       = 2'b00;
    localparam logic [1:0] SrcAOldPc    = 2'b01;
    localparam logic [1:0] SrcARs1      = 2'b10;

    localparam logic [1:0] SrcBRs2      = 2'b00;
    localparam logic [1:0] SrcBImm      = 2'b01;
    localparam logic [1:0] SrcBFour     = 2'b10;

    localparam logic [1:0] AluOpAdd     = 2'b00;
    localparam logic [1:0] AluOpSub     = 2'b01;
    localparam logic [1:0] AluOpFunct   = 2'b10;

    localparam logic [1:0] ResAluReg    = 2'b00;
    localparam logic [1:0] ResMemData   = 2'b01;
    localparam logic [1:0] ResAluDirect = 2'b10;

    localparam logic [1:0] ImmI         = 2'b00;
    localparam logic [1:0] ImmS         = 2'b01;
    localparam logic [1:0] ImmB         = 2'b10;
    localparam logic [1:0] ImmJ         = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_w;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_w;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       illegal;
    } ctrl_word_t;

    function automatic logic [1:0] imm_src_of(logic [6:0] op);
        logic [1:0] imm;
        unique case (op)
            OpLw, OpIType: imm = ImmI;
            OpSw:          imm = ImmS;
            OpBeq:         imm = ImmB;
            OpJal:         imm = ImmJ;
            default:       imm = ImmI;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The controller uses the master modport,
// the datapath (or a testbench standing in for it) uses slave.
interface multicycle_ctrl_if;
    logic [6:0] op_code;
    logic       zero;
    logic       mem_rdy;
    logic       mem_req;
    logic       mem_w;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_w;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       illegal;

    modport master (
        input  op_code, zero, mem_rdy,
        output mem_req, mem_w, adr_src, ir_write, pc_write, reg_w,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal
    );

    modport slave (
        output op_code, zero, mem_rdy,
        input  mem_req, mem_w, adr_src, ir_write, pc_write, reg_w,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal
    );
endinterface

// File: rtl/mc_state_decoder.sv
// Pure state -> control word lookup for the multicycle controller. Input-dependent
// qualification (mem_rdy, zero, reset) is applied by the caller.
module mc_state_decoder
    import riscv_pkg::*;
(
    input  mc_state_e  state_i,
    output ctrl_word_t cw_o
);

    always_comb begin
        cw_o = '0;
        unique case (state_i)
            StFetch: begin
                cw_o.mem_req    = 1'b1;
                cw_o.adr_src    = 1'b0;
                cw_o.ir_write   = 1'b1;
                cw_o.alu_src_a  = SrcAPc;
                cw_o.alu_src_b  = SrcBFour;
                cw_o.alu_op     = AluOpAdd;
                cw_o.result_src = ResAluDirect;
            end
            StDecode: begin
                cw_o.alu_src_a = SrcAOldPc;
                cw_o.alu_src_b = SrcBImm;
                cw_o.alu_op    = AluOpAdd;
            end
            StMemAdr: begin
                cw_o.alu_src_a = SrcARs1;
                cw_o.alu_src_b = SrcBImm;
                cw_o.alu_op    = AluOpAdd;
            end
            StMemRead: begin
                cw_o.mem_req    = 1'b1;
                cw_o.adr_src    = 1'b1;
                cw_o.result_src = ResAluReg;
            end
            StMemWb: begin
                cw_o.result_src = ResMemData;
                cw_o.reg_w      = 1'b1;
            end
            StMemWrite: begin
                cw_o.mem_req = 1'b1;
                cw_o.mem_w   = 1'b1;
                cw_o.adr_src = 1'b1;
            end
            StExecR: begin
                cw_o.alu_src_a = SrcARs1;
                cw_o.alu_src_b = SrcBRs2;
                cw_o.alu_op    = AluOpFunct;
            end
            StExecI: begin
                cw_o.alu_src_a = SrcARs1;
                cw_o.alu_src_b = SrcBImm;
                cw_o.alu_op    = AluOpFunct;
            end
            StAluWb: begin
                cw_o.result_src = ResAluReg;
                cw_o.reg_w      = 1'b1;
            end
            StBeq: begin
                cw_o.alu_src_a  = SrcARs1;
                cw_o.alu_src_b  = SrcBRs2;
                cw_o.alu_op     = AluOpSub;
                cw_o.result_src = ResAluReg;
                cw_o.branch     = 1'b1;
            end
            StJal: begin
                cw_o.alu_src_a  = SrcAOldPc;
                cw_o.alu_src_b  = SrcBFour;
                cw_o.alu_op     = AluOpAdd;
                cw_o.result_src = ResAluReg;
                cw_o.pc_update  = 1'b1;
            end
            StTrap: begin
                cw_o.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (LW, SW, R/I-type, BEQ, JAL) with req/rdy memory handshake.
// Define MC_PERF_CNT_EN to add cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned PERF_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]  cycle_cnt,
    output logic [PERF_W-1:0]  instret_cnt
`endif
);

    if (PERF_W < 1) begin : g_perf_w_check
        $error("PERF_W must be at least 1");
    end

    mc_state_e  state_q, state_d;
    ctrl_word_t cw;

    mc_state_decoder u_state_decoder (
        .state_i (state_q),
        .cw_o    (cw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (bus.mem_rdy) state_d = StDecode;
            StDecode: begin
                unique case (bus.op_code)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRType:    state_d = StExecR;
                    OpIType:    state_d = StExecI;
                    OpBeq:      state_d = StBeq;
                    OpJal:      state_d = StJal;
                    default:    state_d = StTrap;
                endcase
            end
            StMemAdr:   state_d = (bus.op_code == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  if (bus.mem_rdy) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (bus.mem_rdy) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase
    end

    // Reset blanks every output so an aborted instruction cannot write anything.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_w      = 1'b0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_w      = 1'b0;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.result_src = 2'b00;
        bus.imm_src    = 2'b00;
        bus.illegal    = 1'b0;
        if (!rst) begin
            bus.mem_req    = cw.mem_req;
            bus.mem_w      = cw.mem_w;
            bus.adr_src    = cw.adr_src;
            bus.ir_write   = cw.ir_write & bus.mem_rdy;
            bus.pc_write   = cw.pc_update | (cw.ir_write & bus.mem_rdy) | (cw.branch & bus.zero);
            bus.reg_w      = cw.reg_w;
            bus.alu_src_a  = cw.alu_src_a;
            bus.alu_src_b  = cw.alu_src_b;
            bus.alu_op     = cw.alu_op;
            bus.result_src = cw.result_src;
            bus.imm_src    = imm_src_of(bus.op_code);
            bus.illegal    = cw.illegal;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [PERF_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [PERF_W-1:0] instret_cnt_q, instret_cnt_d;
    logic              retire;

    assign retire = (state_d == StFetch) &&
                    (state_q inside {StMemWb, StMemWrite, StAluWb, StBeq});

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + PERF_W'(1);
        instret_cnt_d = instret_cnt_q + (retire ? PERF_W'(1) : PERF_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each cycle's expected control outputs are pushed
// when inputs are driven and popped against the DUT at the following negedge.
module tb_multicycle_ctrl;

    typedef enum int {
        TFetch, TDecode, TMemAdr, TMemRead, TMemWb, TMemWrite,
        TExecR, TExecI, TAluWb, TBeq, TJal, TTrap
    } tst_e;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BQ = 7'b1100011;
    localparam logic [6:0] OP_JL = 7'b1101111;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_ctrl #(
        .PERF_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    // {mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, a[2], b[2], aluop[2], res[2], imm[2], ill}
    function automatic logic [16:0] observed();
        return {bus.mem_req, bus.mem_w, bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_w,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src, bus.imm_src,
                bus.illegal};
    endfunction

    function automatic logic [16:0] model(tst_e st, logic [6:0] op, logic rdy, logic z, logic r);
        logic       req = 0, w = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ill = 0;
        logic [1:0] a = 0, b = 0, aop = 0, res = 0, imm = 0;
        if (r) return '0;
        case (op)
            OP_LW, OP_I: imm = 2'b00;
            OP_SW:       imm = 2'b01;
            OP_BQ:       imm = 2'b10;
            OP_JL:       imm = 2'b11;
            default:     imm = 2'b00;
        endcase
        case (st)
            TFetch:    begin req = 1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
            TDecode:   begin a = 2'b01; b = 2'b01; end
            TMemAdr:   begin a = 2'b10; b = 2'b01; end
            TMemRead:  begin req = 1; adr = 1; end
            TMemWb:    begin res = 2'b01; rw = 1; end
            TMemWrite: begin req = 1; w = 1; adr = 1; end
            TExecR:    begin a = 2'b10; b = 2'b00; aop = 2'b10; end
            TExecI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            TAluWb:    begin rw = 1; end
            TBeq:      begin a = 2'b10; aop = 2'b01; pcw = z; end
            TJal:      begin a = 2'b01; b = 2'b10; pcw = 1; end
            TTrap:     begin ill = 1; end
            default: ;
        endcase
        return {req, w, adr, irw, pcw, rw, a, b, aop, res, imm, ill};
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare at the negedge.
    task automatic step(string tag, tst_e st, logic [6:0] op, logic rdy, logic z, logic r);
        logic [16:0] exp;
        rst         = r;
        bus.op_code = op;
        bus.mem_rdy = rdy;
        bus.zero    = z;
        exp_q.push_back(model(st, op, rdy, z, r));
        @(negedge clk);
        exp = exp_q.pop_front();
        check_eq(tag, {15'b0, observed()}, {15'b0, exp});
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(string tag, logic [6:0] op, int fetch_waits, int mem_waits,
                             logic z);
        for (int i = 0; i < fetch_waits; i++) step({tag, "/fetch_wait"}, TFetch, op, 0, rnd(), 0);
        step({tag, "/fetch"}, TFetch, op, 1, rnd(), 0);
        step({tag, "/decode"}, TDecode, op, rnd(), rnd(), 0);
        case (op)
            OP_R: begin
                step({tag, "/execr"}, TExecR, op, rnd(), rnd(), 0);
                step({tag, "/aluwb"}, TAluWb, op, rnd(), rnd(), 0);
            end
            OP_I: begin
                step({tag, "/execi"}, TExecI, op, rnd(), rnd(), 0);
                step({tag, "/aluwb"}, TAluWb, op, rnd(), rnd(), 0);
            end
            OP_LW: begin
                step({tag, "/memadr"}, TMemAdr, op, rnd(), rnd(), 0);
                for (int i = 0; i < mem_waits; i++)
                    step({tag, "/memread_wait"}, TMemRead, op, 0, rnd(), 0);
                step({tag, "/memread"}, TMemRead, op, 1, rnd(), 0);
                step({tag, "/memwb"}, TMemWb, op, rnd(), rnd(), 0);
            end
            OP_SW: begin
                step({tag, "/memadr"}, TMemAdr, op, rnd(), rnd(), 0);
                for (int i = 0; i < mem_waits; i++)
                    step({tag, "/memwrite_wait"}, TMemWrite, op, 0, rnd(), 0);
                step({tag, "/memwrite"}, TMemWrite, op, 1, rnd(), 0);
            end
            OP_BQ: step({tag, "/beq"}, TBeq, op, rnd(), z, 0);
            OP_JL: begin
                step({tag, "/jal"}, TJal, op, rnd(), rnd(), 0);
                step({tag, "/aluwb"}, TAluWb, op, rnd(), rnd(), 0);
            end
            default: step({tag, "/trap"}, TTrap, op, rnd(), rnd(), 0);
        endcase
    endtask

    initial begin
        rst         = 1'b1;
        bus.op_code = '0;
        bus.mem_rdy = 1'b0;
        bus.zero    = 1'b0;

        step("reset0", TFetch, OP_R, 1, 1, 1);
        step("reset1", TFetch, OP_SW, 1, 0, 1);

`ifdef MC_PERF_CNT_EN
        for (int i = 0; i < 3; i++) run_instr("perf_rtype", OP_R, 0, 0, 0);
        check_eq("cycle_cnt", cycle_cnt, 32'd12);
        check_eq("instret_cnt", instret_cnt, 32'd3);
`endif

        run_instr("add", OP_R, 0, 0, 0);
        run_instr("lw", OP_LW, 0, 2, 0);
        run_instr("beq_taken", OP_BQ, 0, 0, 1);
        run_instr("beq_not_taken", OP_BQ, 0, 0, 0);
        run_instr("jal", OP_JL, 0, 0, 0);
        run_instr("addi", OP_I, 1, 0, 0);
        run_instr("sw", OP_SW, 0, 1, 0);
        run_instr("lw_fast", OP_LW, 2, 0, 0);

        // Unsupported opcode: trap must hold with no memory traffic until reset.
        run_instr("illegal", 7'b0000000, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("trap_hold", TTrap, 7'b0000000, rnd(), rnd(), 0);
        step("trap_reset", TTrap, 7'b0000000, 1, 0, 1);
        run_instr("after_trap", OP_R, 0, 0, 0);

        // Reset in the middle of a stalled store aborts it.
        step("swabort/fetch", TFetch, OP_SW, 1, 0, 0);
        step("swabort/decode", TDecode, OP_SW, 0, 0, 0);
        step("swabort/memadr", TMemAdr, OP_SW, 0, 0, 0);
        step("swabort/wait", TMemWrite, OP_SW, 0, 0, 0);
        step("swabort/wait", TMemWrite, OP_SW, 0, 0, 0);
        step("swabort/rst", TMemWrite, OP_SW, 1, 0, 1);
        run_instr("after_abort", OP_JL, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle variant of the RV32I core.
- Sequences one shared ALU, one unified instruction/data memory and the register file over several cycles per instruction.
- Sits between the instruction register opcode field and the datapath select/enable lines.
- Supports LW, SW, R-type, I-type ALU, BEQ and JAL. Memory accesses use a req/rdy handshake, so wait states are allowed.

Parameters:
- PERF_W, 32, width of performance counters (used only with MC_PERF_CNT_EN).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- op_code  in  7  opcode field of the instruction register
- zero  in  1  ALU zero flag
- mem_rdy  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_w  out  1  write strobe (valid with mem_req)
- adr_src  out  1  memory address select: 0=PC, 1=ALU result register
- ir_write  out  1  load the instruction register and old-PC register
- pc_write  out  1  PC enable: pc_update | (branch & zero)
- reg_w  out  1  register-file write enable
- alu_src_a  out  2  A select: 00=PC, 01=old PC, 10=rs1
- alu_src_b  out  2  B select: 00=rs2, 01=imm, 10=const 4
- alu_op  out  2  to ALU decoder: 00=add, 01=sub, 10=funct-decoded
- result_src  out  2  result select: 00=ALU result register, 01=mem data register, 10=ALU output direct
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- illegal  out  1  sticky unsupported-opcode flag
- cycle_cnt  out  PERF_W  (MC_PERF_CNT_EN only)
- instret_cnt  out  PERF_W  (MC_PERF_CNT_EN only)

Behaviour:
- Moore FSM with a registered state. Reset state is FETCH; illegal resets to 0.
- While rst=1, every output except the counters is forced to 0. rst asserted mid-instruction aborts it; the FSM is in FETCH on the first cycle after rst falls. No partial register or memory write occurs after rst is sampled.
- Unlisted outputs are 0 in every state. imm_src is decoded from op_code in every state: LW/I-type → 00, SW → 01, BEQ → 10, JAL → 11, otherwise 00.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_update are asserted only when mem_rdy=1.
  - Stay in FETCH while mem_rdy=0; go to DECODE when mem_rdy=1.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00 (precomputes the branch/jump target).
  - Next state: LW/SW (0000011/0100011) → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL; any other opcode → TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state: LW → MEMREAD, SW → MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Wait for mem_rdy, then → MEMWB.
- MEMWB: result_src=01, reg_w=1 → FETCH.
- MEMWRITE: mem_req=1, mem_w=1, adr_src=1. Wait for mem_rdy, then → FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 → ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 → ALUWB.
- ALUWB: result_src=00, reg_w=1 → FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
  - pc_write equals zero → FETCH.
- JAL:
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 → ALUWB (writes old PC+4 to rd).
- TRAP: illegal=1, held until rst. No mem_req or writes are issued.
- Handshake rules:
  - mem_req stays high and address/mem_w stay stable until the cycle mem_rdy=1. That cycle completes the transfer.
  - mem_rdy when mem_req=0 is ignored.
- Latency with zero wait states, counted in cycles per instruction:
  - BEQ = 3
  - R-type, I-type, SW, JAL = 4
  - LW = 5
  - Each wait state adds 1 cycle.

Optional Feature:
- MC_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle when rst=0.
  - instret_cnt increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Both counters wrap modulo 2^PERF_W and clear on rst.
- MC_PERF_CNT_EN undefined: the counter ports and logic are absent.

Decomposition:
- Package riscv_pkg holds:
  - opcode enum (LW, SW, BEQ, I_TYPE, R_TYPE, JAL), shared with the single-cycle decoder;
  - state enum mc_state_e;
  - localparams for the alu_src_a, alu_src_b, result_src, imm_src and alu_op encodings.
- Sub-module mc_state_decoder: purely combinational mapping of state to control word. The FSM and counters stay in multicycle_ctrl.

Test Plan:
- add x3,x1,x2 (op 0110011), mem_rdy=1 → states FETCH, DECODE, EXECR, ALUWB; reg_w=1 only in cycle 4; alu_op=10 in cycle 3.
- lw (op 0000011), mem_rdy low for 2 cycles in MEMREAD → mem_req and adr_src=1 held stable 3 cycles; MEMWB result_src=01; 7 cycles total.
- beq with zero=1 then zero=0 → pc_write=1 in the BEQ cycle for the first, 0 for the second; both return to FETCH after 3 cycles.
- jal (op 1101111) → imm_src=11; pc_write in JAL state; ALUWB reg_w=1 with result_src=00.
- op_code 0000000 → TRAP after DECODE; illegal=1 and held; no mem_req for 10 cycles; rst=1 clears illegal and the next state is FETCH.
- rst pulsed during MEMWRITE wait → mem_w=0 during rst; FETCH follows. With MC_PERF_CNT_EN, 3 back-to-back R-type ops → instret_cnt=3, cycle_cnt=12.
